// File: rtl/seq_repeat_monitor_pkg.sv
`default_nettype none
// ============================================================================
// Module      : seq_mon_pkg
// Description : Shared state encoding and saturating-arithmetic helpers for
//               the repeat-sequence monitor.
// Revision    : 1.0 - initial release
// ============================================================================
package seq_mon_pkg;

    localparam int c_STATE_W = 2;

    typedef enum logic [c_STATE_W-1:0] {
        IDLE  = 2'd0,
        WARM  = 2'd1,
        CHECK = 2'd2,
        DONE  = 2'd3
    } state_t;

    function automatic int run_width(input int reps);
        return $clog2(reps + 1);
    endfunction

    // Adds in 33 bits so the clamp is exact for any width up to 32.
    function automatic logic [31:0] sat_add(input logic [31:0] a,
                                            input logic [31:0] b,
                                            input int          width);
        logic [32:0] w_sum;
        logic [32:0] w_max;
        w_sum = {1'b0, a} + {1'b0, b};
        w_max = (33'd1 << width) - 33'd1;
        return (w_sum > w_max) ? w_max[31:0] : w_sum[31:0];
    endfunction

endpackage
`default_nettype wire

// File: rtl/seq_repeat_monitor_if.sv
`default_nettype none
// ============================================================================
// Module      : seq_repeat_monitor_if
// Description : Summary bundle and valid/ready handshake from the monitor to
//               the finish/report stage.
// Revision    : 1.0 - initial release
// ============================================================================
interface seq_repeat_monitor_if #(
    parameter int CNT_W = 16
);
    logic [CNT_W-1:0] pass_cnt;
    logic [CNT_W-1:0] fail_cnt;
    logic [CNT_W-1:0] first_fail;
    logic             done_valid;
    logic             done_ready;
    logic             all_ok;

    modport master (
        output pass_cnt, fail_cnt, first_fail, done_valid, all_ok,
        input  done_ready
    );

    modport slave (
        input  pass_cnt, fail_cnt, first_fail, done_valid, all_ok,
        output done_ready
    );
endinterface
`default_nettype wire

// File: rtl/seq_repeat_monitor_sat_counter.sv
`default_nettype none
// ============================================================================
// Module      : sat_counter
// Description : Clearable counter that adds a variable amount and sticks at
//               all-ones instead of wrapping.
// Revision    : 1.0 - initial release
// ============================================================================
module sat_counter
    import seq_mon_pkg::*;
#(
    parameter int W     = 16,
    parameter int INC_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic [INC_W-1:0] inc,
    output logic [W-1:0]     count
);
    logic [W-1:0] r_count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= '0;
        end else if (clr) begin
            r_count <= '0;
        end else begin
            r_count <= W'(sat_add(32'(r_count), 32'(inc), W));
        end
    end

    assign count = r_count;
endmodule
`default_nettype wire

// File: rtl/seq_repeat_monitor.sv
`default_nettype none
// ============================================================================
// Module      : seq_repeat_monitor
// Description : Evaluates the overlapping "sig for REPS beats" sequence inside
//               a start/stop window and hands a one-shot summary downstream.
// Revision    : 1.0 - initial release
// ============================================================================
module seq_repeat_monitor
    import seq_mon_pkg::*;
#(
    parameter int REPS   = 2,
    parameter int WARMUP = 1,
    parameter int CNT_W  = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic                stop,
    input  logic                sig,
    output logic                pass_pulse,
    output logic                fail_pulse,
    output logic [7:0]          fail_inc,
    seq_repeat_monitor_if.master mon_if
);
    localparam int                   c_RUN_W      = run_width(REPS);
    localparam logic [c_RUN_W-1:0]   c_REPS       = c_RUN_W'(REPS);
    localparam logic [c_RUN_W-1:0]   c_REPS_M1    = c_RUN_W'(REPS - 1);
    localparam logic [CNT_W-1:0]     c_ALL_ONES   = '1;
    localparam logic [31:0]          c_WARM_LAST  = (WARMUP > 0) ? 32'(WARMUP - 1) : 32'd0;
    localparam state_t               c_ENTRY      = (WARMUP == 0) ? CHECK : WARM;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [c_RUN_W-1:0] r_run;
    logic [c_RUN_W-1:0] w_run_nxt;
    logic [CNT_W-1:0]   r_first_fail;
    logic [CNT_W-1:0]   w_cyc;
    logic [CNT_W-1:0]   w_pass_cnt;
    logic [CNT_W-1:0]   w_fail_cnt;
    logic               r_pass_pulse;
    logic               r_fail_pulse;
    logic [7:0]         r_fail_inc;
    logic               w_clr;
    logic               w_eval;
    logic               w_active;
    logic               w_pass;
    logic               w_fail;
    logic [7:0]         w_fail_inc;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_clr       = 1'b0;
        w_eval      = 1'b0;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_clr       = 1'b1;
                    w_state_nxt = c_ENTRY;
                end
            end
            WARM: begin
                if (stop) begin
                    w_state_nxt = DONE;
                end else if (32'(w_cyc) >= c_WARM_LAST) begin
                    w_state_nxt = CHECK;
                end
            end
            CHECK: begin
                w_eval = 1'b1;
                if (stop) begin
                    w_state_nxt = DONE;
                end
            end
            DONE: begin
                if (mon_if.done_ready) begin
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    assign w_active = (r_state == WARM) || (r_state == CHECK);

    // run saturates at REPS, so min(run, REPS-1)+1 is the number of live attempts.
    always_comb begin
        w_run_nxt  = r_run;
        w_pass     = 1'b0;
        w_fail     = 1'b0;
        w_fail_inc = '0;
        if (w_eval) begin
            if (sig) begin
                w_run_nxt = (r_run >= c_REPS) ? c_REPS : r_run + c_RUN_W'(1);
                w_pass    = (r_run >= c_REPS_M1);
            end else begin
                w_fail     = 1'b1;
                w_fail_inc = 8'((r_run >= c_REPS_M1) ? c_REPS_M1 : r_run) + 8'd1;
                w_run_nxt  = '0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_run        <= '0;
            r_first_fail <= c_ALL_ONES;
            r_pass_pulse <= 1'b0;
            r_fail_pulse <= 1'b0;
            r_fail_inc   <= '0;
        end else begin
            r_run <= w_clr ? '0 : w_run_nxt;
            if (w_clr) begin
                r_first_fail <= c_ALL_ONES;
            end else if (w_fail && (r_first_fail == c_ALL_ONES)) begin
                r_first_fail <= w_cyc;
            end
            // The stop beat still counts, but its pulses are suppressed.
            r_pass_pulse <= w_pass && !stop;
            r_fail_pulse <= w_fail && !stop;
            r_fail_inc   <= stop ? 8'd0 : w_fail_inc;
        end
    end

    sat_counter #(.W(CNT_W), .INC_W(1)) u_pass_cnt (
        .clk   (clk),
        .rst   (rst),
        .clr   (w_clr),
        .inc   (w_pass),
        .count (w_pass_cnt)
    );

    sat_counter #(.W(CNT_W), .INC_W(8)) u_fail_cnt (
        .clk   (clk),
        .rst   (rst),
        .clr   (w_clr),
        .inc   (w_fail_inc),
        .count (w_fail_cnt)
    );

    sat_counter #(.W(CNT_W), .INC_W(1)) u_cyc_cnt (
        .clk   (clk),
        .rst   (rst),
        .clr   (w_clr),
        .inc   (w_active),
        .count (w_cyc)
    );

    assign pass_pulse         = r_pass_pulse;
    assign fail_pulse         = r_fail_pulse;
    assign fail_inc           = r_fail_inc;
    assign mon_if.pass_cnt    = w_pass_cnt;
    assign mon_if.fail_cnt    = w_fail_cnt;
    assign mon_if.first_fail  = r_first_fail;
    assign mon_if.done_valid  = (r_state == DONE);
    assign mon_if.all_ok      = (r_state == DONE) && (w_fail_cnt == '0) && (w_pass_cnt != '0);
endmodule
`default_nettype wire
